// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: holds the PC, drives the word-indexed instruction memory
// and captures the returned word into an IF/ID register with a valid/ready handshake.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] pc_out,
  output logic [1:0]  fault,
  output logic [31:0] fetch_count,
  output logic [1:0]  state_dbg
);

  // Handshake toward decode: the IF/ID word transfers on a cycle where
  // id_valid && id_ready; id_valid, once set, holds until transfer or flush.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

  state_t state;
  logic   advance;
  logic   out_of_range;
  logic   redir_aligned;

  assign imem_addr     = {2'b00, pc_out[31:2]};
  assign advance       = !id_valid || id_ready;
  assign out_of_range  = imem_addr >= DEPTH_W;
  assign redir_aligned = redirect_target[1:0] == 2'b00;
  assign state_dbg     = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= BOOT;
      pc_out      <= RESET_PC;
      id_valid    <= 1'b0;
      id_instr    <= NOP_INSTR;
      id_pc       <= 32'd0;
      id_pc_plus4 <= 32'd4;
      fault       <= 2'b00;
      fetch_count <= 32'd0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          // A redirect flushes IF/ID even when decode is taking it this cycle.
          if (redirect_valid && redir_aligned) begin
            pc_out   <= redirect_target;
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
          end else if (redirect_valid) begin
            pc_out   <= redirect_target;
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            fault    <= 2'b10;
            state    <= HALT;
          end else if (advance && out_of_range) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            fault    <= 2'b01;
            state    <= HALT;
          end else if (advance) begin
            id_instr    <= imem_data;
            id_pc       <= pc_out;
            id_pc_plus4 <= pc_out + 32'd4;
            id_valid    <= 1'b1;
            pc_out      <= pc_out + 32'd4;
            fetch_count <= fetch_count + 32'd1;
          end
        end
        HALT: begin
          if (redirect_valid && redir_aligned) begin
            pc_out <= redirect_target;
            fault  <= 2'b00;
            state  <= RUN;
          end else if (redirect_valid) begin
            fault <= 2'b10;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: boot, streaming, back-pressure, redirects,
// range and alignment faults, and reset in mid-stream.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [1:0]  S_BOOT = 2'd0;
  localparam logic [1:0]  S_RUN  = 2'd1;
  localparam logic [1:0]  S_HALT = 2'd2;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] pc_out;
  logic [1:0]  fault;
  logic [31:0] fetch_count;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .pc_out(pc_out),
    .fault(fault), .fetch_count(fetch_count), .state_dbg(state_dbg)
  );

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: word w holds {8'hA5, w[23:0]}, so every word is distinct.
  function automatic logic [31:0] mem_word(input logic [31:0] w);
    return {8'hA5, w[23:0]};
  endfunction

  always_comb imem_data = mem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rv, input logic [31:0] tgt, input logic rdy);
    redirect_valid  = rv;
    redirect_target = tgt;
    id_ready        = rdy;
  endtask

  task automatic check_captured(input string tag, input logic [31:0] p, input logic [31:0] cnt);
    check({tag, "_valid"}, {31'd0, id_valid}, 32'd1);
    check({tag, "_pc"}, id_pc, p);
    check({tag, "_pc4"}, id_pc_plus4, p + 32'd4);
    check({tag, "_instr"}, id_instr, mem_word(p >> 2));
    check({tag, "_count"}, fetch_count, cnt);
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 32'd0, 1'b1);
    step();
    step();
    check("rst_state", {30'd0, state_dbg}, {30'd0, S_BOOT});
    check("rst_pc", pc_out, 32'd0);
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_instr", id_instr, NOP);
    check("rst_idpc", id_pc, 32'd0);
    check("rst_pc4", id_pc_plus4, 32'd4);
    check("rst_fault", {30'd0, fault}, 32'd0);
    check("rst_count", fetch_count, 32'd0);

    // BOOT cycle ignores a redirect and captures nothing
    rst = 1'b1;
    drive(1'b1, 32'h100, 1'b1);
    step();
    drive(1'b0, 32'd0, 1'b1);
    check("boot_state", {30'd0, state_dbg}, {30'd0, S_RUN});
    check("boot_valid", {31'd0, id_valid}, 32'd0);
    check("boot_pc", pc_out, 32'd0);
    check("boot_addr", imem_addr, 32'd0);

    for (int i = 0; i < 3; i++) begin
      step();
      check_captured("stream", 32'(i * 4), 32'(i + 1));
      check("stream_addr", imem_addr, 32'(i + 1));
    end

    // back-pressure while id_pc = 8
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_captured("stall", 32'd8, 32'd3);
      check("stall_pc", pc_out, 32'd12);
    end
    id_ready = 1'b1;
    step();
    check_captured("resume12", 32'd12, 32'd4);
    step();
    check_captured("resume16", 32'd16, 32'd5);

    // redirect while id_valid = 1 and decode ready
    drive(1'b1, 32'h40, 1'b1);
    step();
    drive(1'b0, 32'd0, 1'b1);
    check("redir_valid", {31'd0, id_valid}, 32'd0);
    check("redir_instr", id_instr, NOP);
    check("redir_addr", imem_addr, 32'd16);
    check("redir_count", fetch_count, 32'd5);
    step();
    check_captured("redir_cap", 32'h40, 32'd6);

    // run off the end of memory
    drive(1'b1, 32'h3F8, 1'b1);
    step();
    drive(1'b0, 32'd0, 1'b1);
    step();
    check_captured("edge254", 32'h3F8, 32'd7);
    step();
    check_captured("edge255", 32'h3FC, 32'd8);
    step();
    check("oor_valid", {31'd0, id_valid}, 32'd0);
    check("oor_fault", {30'd0, fault}, 32'd1);
    check("oor_state", {30'd0, state_dbg}, {30'd0, S_HALT});
    check("oor_pc", pc_out, 32'd1024);
    step();
    check("halt_pc", pc_out, 32'd1024);
    check("halt_valid", {31'd0, id_valid}, 32'd0);
    check("halt_count", fetch_count, 32'd8);
    drive(1'b1, 32'd0, 1'b1);
    step();
    drive(1'b0, 32'd0, 1'b1);
    check("exit_fault", {30'd0, fault}, 32'd0);
    check("exit_state", {30'd0, state_dbg}, {30'd0, S_RUN});
    check("exit_pc", pc_out, 32'd0);
    step();
    check_captured("exit_cap", 32'd0, 32'd9);

    // misaligned redirect, repeated in HALT, then aligned recovery
    drive(1'b1, 32'h22, 1'b1);
    step();
    check("mis_fault", {30'd0, fault}, 32'd2);
    check("mis_state", {30'd0, state_dbg}, {30'd0, S_HALT});
    check("mis_valid", {31'd0, id_valid}, 32'd0);
    check("mis_pc", pc_out, 32'h22);
    check("mis_instr", id_instr, NOP);
    step();
    check("mis2_fault", {30'd0, fault}, 32'd2);
    check("mis2_state", {30'd0, state_dbg}, {30'd0, S_HALT});
    drive(1'b1, 32'h20, 1'b1);
    step();
    drive(1'b0, 32'd0, 1'b1);
    check("al_fault", {30'd0, fault}, 32'd0);
    check("al_pc", pc_out, 32'h20);
    step();
    check_captured("al_cap", 32'h20, 32'd10);

    // reset mid-stream with a redirect pending
    rst = 1'b0;
    drive(1'b1, 32'h80, 1'b1);
    step();
    check("mrst_pc", pc_out, 32'd0);
    check("mrst_valid", {31'd0, id_valid}, 32'd0);
    check("mrst_count", fetch_count, 32'd0);
    check("mrst_fault", {30'd0, fault}, 32'd0);
    check("mrst_state", {30'd0, state_dbg}, {30'd0, S_BOOT});
    rst = 1'b1;
    drive(1'b0, 32'd0, 1'b1);
    step();
    check("mrst_boot_valid", {31'd0, id_valid}, 32'd0);
    step();
    check_captured("mrst_cap", 32'd0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the word-indexed instruction memory.
- Holds the PC and drives the memory word address; the memory returns its word combinationally in the same cycle.
- Captures the returned word into an IF/ID register with a valid/ready handshake toward decode.
- Handles redirects (branch/jump), back-pressure, and out-of-range or misaligned fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset.
- IMEM_DEPTH, 256, number of 32-bit words in instruction memory; word index >= IMEM_DEPTH is out of range.
- NOP_INSTR, 32'h0000_0013, value driven on id_instr whenever the IF/ID register is invalid.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- imem_addr  out  32  word index to instruction memory, {2'b00, pc[31:2]}, combinational from pc.
- imem_data  in  32  instruction word returned combinationally for imem_addr.
- redirect_valid  in  1  take redirect_target this cycle.
- redirect_target  in  32  new byte-address PC.
- id_ready  in  1  decode accepts the IF/ID contents this cycle.
- id_valid  out  1  IF/ID register holds a live instruction.
- id_instr  out  32  captured instruction.
- id_pc  out  32  byte PC of id_instr.
- id_pc_plus4  out  32  id_pc + 4, modulo 2^32.
- pc_out  out  32  current fetch PC.
- fault  out  2  00 none, 01 out of range, 10 misaligned redirect.
- fetch_count  out  32  number of instructions captured into IF/ID.

Behaviour:
- Reset (rst == 0 at a clock edge):
  - pc = RESET_PC, state = BOOT, id_valid = 0, id_instr = NOP_INSTR, id_pc = 0, id_pc_plus4 = 4, fault = 00, fetch_count = 0.
  - Reset asserted mid-operation discards any pending instruction and redirect.
- States are BOOT, RUN and HALT.
- BOOT: lasts exactly 1 cycle after reset is released. No capture; redirect_valid is ignored. Next state is RUN.
- RUN: define advance = !id_valid || id_ready. Evaluate in priority order:
  1. redirect_valid with redirect_target[1:0] == 0: pc <= redirect_target, id_valid <= 0, id_instr <= NOP_INSTR. This flushes the IF/ID register even if it is being handshaken. No capture this cycle.
  2. redirect_valid with redirect_target[1:0] != 0: pc <= redirect_target, id_valid <= 0, fault <= 10, state <= HALT.
  3. advance with pc[31:2] >= IMEM_DEPTH: id_valid <= 0, fault <= 01, state <= HALT, pc holds.
  4. advance, otherwise: id_instr <= imem_data, id_pc <= pc, id_pc_plus4 <= pc + 4, id_valid <= 1, pc <= pc + 4 (wraps at 2^32), fetch_count <= fetch_count + 1 (wraps).
  5. No advance (id_valid && !id_ready): pc and the IF/ID register hold.
- Latency: imem_addr for PC p is presented in cycle n; id_instr/id_valid reflect it from cycle n+1.
- Throughput: 1 instruction per cycle while id_ready stays high.
- HALT:
  - No capture; id_valid = 0; pc holds; imem_addr continues to reflect pc.
  - An aligned redirect_valid sets pc <= redirect_target, fault <= 00, state <= RUN.
  - A misaligned redirect keeps state HALT and sets fault = 10.
  - Only reset or an aligned redirect leaves HALT.
- While id_valid = 0, id_instr reads NOP_INSTR.
- Simultaneous events:
  - Redirect together with id_ready: the held instruction counts as consumed by decode, then is replaced by the flush; fetch_count is unchanged.
  - Redirect together with an out-of-range PC: the redirect wins.

Test Plan:
- Reset, then release with id_ready = 1 and memory words 0..3 distinct: cycle 1 BOOT with id_valid = 0; then id_pc = 0, 4, 8, 12 on consecutive cycles; fetch_count = 4; imem_addr = 0, 1, 2, 3.
- Back-pressure: id_ready = 0 for 3 cycles while id_pc = 8: id_instr, id_pc and pc (12) hold; no word skipped or duplicated after id_ready returns to 1.
- Redirect to 32'h40 while id_valid = 1: next cycle id_valid = 0, id_instr = 32'h13; following cycle id_pc = 32'h40, imem_addr was 16.
- Run sequentially to pc = 1024 (IMEM_DEPTH = 256): id_valid = 0, fault = 01, pc stays 1024; then redirect to 0 gives fault = 00 and fetch resumes at 0.
- Redirect to 32'h22: fault = 10, state HALT, id_valid = 0; then an aligned redirect to 32'h20 resumes with id_pc = 32'h20.
- Assert rst = 0 mid-stream with a redirect pending: next cycle pc = RESET_PC, id_valid = 0, fetch_count = 0, fault = 00; BOOT repeats.
